// File: rtl/mcu_spi_slave_if.sv
// Target-side byte bus of the MCU SPI slave: per-target strobes, the shared
// received byte and frame-start flag, and one reply byte from each target.
interface mcu_spi_slave_if;
  logic       mcu_sys_strobe;
  logic       mcu_hid_strobe;
  logic       mcu_osd_strobe;
  logic       mcu_sdc_strobe;
  logic       mcu_start;
  logic [7:0] mcu_dout;
  logic [7:0] mcu_sys_din;
  logic [7:0] mcu_hid_din;
  logic [7:0] mcu_osd_din;
  logic [7:0] mcu_sdc_din;

  // The SPI slave drives the byte strobes and collects replies.
  modport master (
    output mcu_sys_strobe,
    output mcu_hid_strobe,
    output mcu_osd_strobe,
    output mcu_sdc_strobe,
    output mcu_start,
    output mcu_dout,
    input  mcu_sys_din,
    input  mcu_hid_din,
    input  mcu_osd_din,
    input  mcu_sdc_din
  );

  // A control target consumes strobes and supplies its reply byte.
  modport slave (
    input  mcu_sys_strobe,
    input  mcu_hid_strobe,
    input  mcu_osd_strobe,
    input  mcu_sdc_strobe,
    input  mcu_start,
    input  mcu_dout,
    output mcu_sys_din,
    output mcu_hid_din,
    output mcu_osd_din,
    output mcu_sdc_din
  );
endinterface

// File: rtl/mcu_spi_slave.sv
// SPI mode-0 slave for the board MCU. Oversamples the SPI pins in clk,
// assembles MSB-first bytes, routes them to the target chosen by the first
// byte of each frame, and shifts the chosen target's reply back on MISO.
module mcu_spi_slave #(
  parameter int SYNC_STAGES = 2,
  parameter int NUM_TARGETS = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic spi_io_ss,
  input  logic spi_io_clk,
  input  logic spi_io_din,
  output logic spi_io_dout,
  mcu_spi_slave_if.master bus
);

  localparam logic [7:0] TGT_NONE = 8'hFF;

  // ---------------------------------------------------------------------------
  // Pin synchronisers
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] ss_sync_q, ss_sync_d;
  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] din_sync_q, din_sync_d;
  // Counts real pin samples since reset so the idle fill is never mistaken
  // for the MCU having released chip select.
  logic [SYNC_STAGES-1:0] fill_q, fill_d;
  logic                   sclk_last_q, sclk_last_d;

  logic ss_s;
  logic sclk_s;
  logic din_s;
  logic sclk_rise;
  logic sclk_fall;

  // Next values of the synchroniser chains
  always_comb begin
    ss_sync_d   = {ss_sync_q[SYNC_STAGES-2:0], spi_io_ss};
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], spi_io_clk};
    din_sync_d  = {din_sync_q[SYNC_STAGES-2:0], spi_io_din};
    fill_d      = {fill_q[SYNC_STAGES-2:0], 1'b1};
    sclk_last_d = sclk_sync_q[SYNC_STAGES-1];
  end

  // Synchroniser flops, reset to the idle pin levels
  always_ff @(posedge clk) begin
    if (reset) begin
      ss_sync_q   <= '1;
      sclk_sync_q <= '0;
      din_sync_q  <= '0;
      fill_q      <= '0;
      sclk_last_q <= 1'b0;
    end else begin
      ss_sync_q   <= ss_sync_d;
      sclk_sync_q <= sclk_sync_d;
      din_sync_q  <= din_sync_d;
      fill_q      <= fill_d;
      sclk_last_q <= sclk_last_d;
    end
  end

  assign ss_s      = ss_sync_q[SYNC_STAGES-1];
  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign din_s     = din_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_last_q;
  assign sclk_fall = ~sclk_s & sclk_last_q;

  // ---------------------------------------------------------------------------
  // Target decode
  // ---------------------------------------------------------------------------
  logic [7:0] tgt_q, tgt_d;
  logic [3:0] tgt_hit;
  logic       tgt_valid;
  logic [7:0] reply_byte;

  // One-hot match of the latched target id; ids without a port never match.
  for (genvar gi = 0; gi < 4; gi++) begin : g_hit
    if (gi < NUM_TARGETS) begin : g_used
      assign tgt_hit[gi] = (tgt_q == 8'(gi));
    end else begin : g_unused
      assign tgt_hit[gi] = 1'b0;
    end
  end

  assign tgt_valid = |tgt_hit;

  // Reply byte of the currently selected target
  always_comb begin
    reply_byte = 8'h00;
    unique case (tgt_hit)
      4'b0001: reply_byte = bus.mcu_sys_din;
      4'b0010: reply_byte = bus.mcu_hid_din;
      4'b0100: reply_byte = bus.mcu_osd_din;
      4'b1000: reply_byte = bus.mcu_sdc_din;
      default: reply_byte = 8'h00;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Frame state, receive, strobes and transmit
  // ---------------------------------------------------------------------------
  logic       armed_q, armed_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [1:0] byte_cnt_q, byte_cnt_d;
  logic [7:0] rx_q, rx_d;
  logic [7:0] tx_q, tx_d;
  logic [7:0] dout_q, dout_d;
  logic [3:0] strobe_q, strobe_d;
  logic       start_q, start_d;
  // Two-stage delay from byte completion to the tx load; the _v stage
  // remembers whether the completed byte actually went to a target.
  logic       ld1_q, ld1_d;
  logic       ld2_q, ld2_d;
  logic       ld1_v_q, ld1_v_d;
  logic       ld2_v_q, ld2_v_d;

  logic       in_frame;
  logic [7:0] rx_shift;

  assign in_frame = armed_q & ~ss_s;
  assign rx_shift = {rx_q[6:0], din_s};

  // Byte assembly, target routing and reply serialisation
  always_comb begin
    armed_d    = armed_q | ((&fill_q) & ss_s);
    bit_cnt_d  = bit_cnt_q;
    byte_cnt_d = byte_cnt_q;
    rx_d       = rx_q;
    tx_d       = tx_q;
    tgt_d      = tgt_q;
    dout_d     = dout_q;
    strobe_d   = 4'b0000;
    start_d    = 1'b0;
    ld1_d      = 1'b0;
    ld1_v_d    = 1'b0;
    ld2_d      = ld1_q;
    ld2_v_d    = ld1_v_q;

    if (!in_frame) begin
      bit_cnt_d  = 3'd0;
      byte_cnt_d = 2'd0;
      rx_d       = 8'h00;
      tx_d       = 8'h00;
      tgt_d      = TGT_NONE;
      ld2_d      = 1'b0;
      ld2_v_d    = 1'b0;
    end else begin
      // The load has priority over a coincident fall. The fall that closes
      // a byte (counter back at 0) does not shift, so the freshly loaded
      // MSB is already on MISO for the next byte's first rising edge.
      if (ld2_q) begin
        tx_d = (ld2_v_q && tgt_valid) ? reply_byte : 8'h00;
      end else if (sclk_fall && (bit_cnt_q != 3'd0)) begin
        tx_d = {tx_q[6:0], 1'b0};
      end

      if (sclk_rise) begin
        rx_d      = rx_shift;
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) begin
          ld1_d = 1'b1;
          if (byte_cnt_q == 2'd0) begin
            tgt_d      = rx_shift;
            byte_cnt_d = 2'd1;
          end else begin
            dout_d     = rx_shift;
            start_d    = (byte_cnt_q == 2'd1) && tgt_valid;
            strobe_d   = tgt_hit;
            ld1_v_d    = 1'b1;
            byte_cnt_d = 2'd2;
          end
        end
      end
    end
  end

  // Frame state registers
  always_ff @(posedge clk) begin
    if (reset) begin
      armed_q    <= 1'b0;
      bit_cnt_q  <= 3'd0;
      byte_cnt_q <= 2'd0;
      rx_q       <= 8'h00;
      tx_q       <= 8'h00;
      tgt_q      <= TGT_NONE;
      dout_q     <= 8'h00;
      strobe_q   <= 4'b0000;
      start_q    <= 1'b0;
      ld1_q      <= 1'b0;
      ld2_q      <= 1'b0;
      ld1_v_q    <= 1'b0;
      ld2_v_q    <= 1'b0;
    end else begin
      armed_q    <= armed_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      rx_q       <= rx_d;
      tx_q       <= tx_d;
      tgt_q      <= tgt_d;
      dout_q     <= dout_d;
      strobe_q   <= strobe_d;
      start_q    <= start_d;
      ld1_q      <= ld1_d;
      ld2_q      <= ld2_d;
      ld1_v_q    <= ld1_v_d;
      ld2_v_q    <= ld2_v_d;
    end
  end

  assign spi_io_dout        = tx_q[7];
  assign bus.mcu_sys_strobe = strobe_q[0];
  assign bus.mcu_hid_strobe = strobe_q[1];
  assign bus.mcu_osd_strobe = strobe_q[2];
  assign bus.mcu_sdc_strobe = strobe_q[3];
  assign bus.mcu_start      = start_q;
  assign bus.mcu_dout       = dout_q;

endmodule

// File: tb/tb_mcu_spi_slave.sv
// Directed and randomized frames for mcu_spi_slave, checked against a
// frame-level model of strobes and MISO reply bytes.
module tb_mcu_spi_slave;
  localparam int SYNC_STAGES = 2;
  localparam int NUM_TARGETS = 4;
  localparam int HALF_SLOW   = 8;
  localparam int HALF_MIN    = SYNC_STAGES + 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic ss = 1'b1;
  logic sclk = 1'b0;
  logic mosi = 1'b0;
  logic miso;

  always #5 clk = ~clk;

  mcu_spi_slave_if bus ();

  logic [7:0] din_fix [4];
  logic       rand_mode = 1'b0;
  logic [7:0] rand_din = 8'h00;
  int         rand_idx = 0;
  logic [7:0] reply_tab [64];

  assign bus.mcu_sys_din = rand_mode ? rand_din : din_fix[0];
  assign bus.mcu_hid_din = din_fix[1];
  assign bus.mcu_osd_din = din_fix[2];
  assign bus.mcu_sdc_din = din_fix[3];

  mcu_spi_slave #(
    .SYNC_STAGES(SYNC_STAGES),
    .NUM_TARGETS(NUM_TARGETS)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .spi_io_ss  (ss),
    .spi_io_clk (sclk),
    .spi_io_din (mosi),
    .spi_io_dout(miso),
    .bus        (bus)
  );

  // Observed strobe events (appended only by the monitor)
  int         ev_tgt [$];
  bit         ev_start [$];
  logic [7:0] ev_data [$];

  always @(negedge clk) begin
    logic [3:0] strb;
    strb = {bus.mcu_sdc_strobe, bus.mcu_osd_strobe, bus.mcu_hid_strobe, bus.mcu_sys_strobe};
    if (!rand_mode) rand_idx = 0;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) begin
        ev_tgt.push_back(i);
        ev_start.push_back(bus.mcu_start);
        ev_data.push_back(bus.mcu_dout);
      end
    end
    if (strb != 4'b0000 && rand_mode && rand_idx < 64) begin
      rand_din = reply_tab[rand_idx];
      rand_idx++;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // SPI master (mode 0): MISO sampled just before each rising edge
  task automatic spi_bit(input logic b, input int half, output logic s);
    mosi = b;
    repeat (half) @(negedge clk);
    s = miso;
    sclk = 1'b1;
    repeat (half) @(negedge clk);
    sclk = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] tx, input int half, output logic [7:0] rx);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      spi_bit(tx[i], half, s);
      rx[i] = s;
    end
  endtask

  task automatic frame_begin(input int half);
    ss = 1'b0;
    repeat (half) @(negedge clk);
  endtask

  task automatic frame_end(input int half);
    repeat (half) @(negedge clk);
    ss = 1'b1;
    mosi = 1'b0;
    repeat (half + 6) @(negedge clk);
  endtask

  // Frame stimulus and model expectations
  logic [7:0] tx_arr [64];
  logic [7:0] rx_arr [64];
  int         exp_tgt [$];
  bit         exp_start [$];
  logic [7:0] exp_data [$];
  logic [7:0] exp_miso [64];

  // Model: byte 0 selects the target; each later byte goes to a valid target
  // with start on the first; the reply during byte k answers byte k-1.
  task automatic build_expect(input int n, input bit use_tab);
    int t;
    exp_tgt.delete();
    exp_start.delete();
    exp_data.delete();
    t = int'(tx_arr[0]);
    for (int k = 0; k < n; k++) begin
      if (k >= 1 && t < NUM_TARGETS) begin
        exp_tgt.push_back(t);
        exp_start.push_back(k == 1);
        exp_data.push_back(tx_arr[k]);
      end
      if (k < 2 || t >= NUM_TARGETS) exp_miso[k] = 8'h00;
      else if (use_tab)              exp_miso[k] = reply_tab[k-2];
      else                           exp_miso[k] = din_fix[t];
    end
  endtask

  task automatic compare(input string tag, input int n, input int base);
    check({tag, " ev_count"}, ev_tgt.size() - base, exp_tgt.size());
    for (int i = 0; i < exp_tgt.size(); i++) begin
      if (base + i < ev_tgt.size()) begin
        check($sformatf("%s ev%0d tgt", tag, i), ev_tgt[base+i], exp_tgt[i]);
        check($sformatf("%s ev%0d start", tag, i), ev_start[base+i], exp_start[i]);
        check($sformatf("%s ev%0d data", tag, i), ev_data[base+i], exp_data[i]);
      end
    end
    for (int k = 0; k < n; k++)
      check($sformatf("%s miso%0d", tag, k), rx_arr[k], exp_miso[k]);
  endtask

  task automatic run_frame(input string tag, input int n, input int half, input bit use_tab);
    int base;
    base = ev_tgt.size();
    build_expect(n, use_tab);
    frame_begin(half);
    for (int k = 0; k < n; k++) send_byte(tx_arr[k], half, rx_arr[k]);
    frame_end(half);
    compare(tag, n, base);
    $display("frame %s: %0d bytes to id %0h, %0d strobes", tag, n, tx_arr[0], ev_tgt.size() - base);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, " strobes"}, {bus.mcu_sdc_strobe, bus.mcu_osd_strobe,
                              bus.mcu_hid_strobe, bus.mcu_sys_strobe}, 4'b0000);
    check({tag, " start"}, bus.mcu_start, 1'b0);
    check({tag, " dout"}, bus.mcu_dout, 8'h00);
    check({tag, " miso"}, miso, 1'b0);
  endtask

  initial begin
    int base;
    logic s;
    logic [7:0] junk;
    din_fix[0] = 8'h5C;
    din_fix[1] = 8'hA7;
    din_fix[2] = 8'h9E;
    din_fix[3] = 8'h3D;

    // Reset state
    reset = 1'b1;
    repeat (4) @(negedge clk);
    check_idle_outputs("reset");
    reset = 1'b0;
    repeat (6) @(negedge clk);

    // Sys frame with fixed reply
    tx_arr[0] = 8'h00; tx_arr[1] = 8'h00; tx_arr[2] = 8'hAA;
    tx_arr[3] = 8'hBB; tx_arr[4] = 8'hCC;
    run_frame("sys", 5, HALF_SLOW, 1'b0);

    // OSD frame
    tx_arr[0] = 8'h02; tx_arr[1] = 8'h11; tx_arr[2] = 8'h22;
    run_frame("osd", 3, HALF_SLOW, 1'b0);

    // Invalid target id
    tx_arr[0] = 8'h07;
    for (int k = 1; k < 4; k++) tx_arr[k] = 8'($urandom_range(0, 255));
    run_frame("invalid", 4, HALF_SLOW, 1'b0);

    // Chip select released after 5 bits of the first data byte
    base = ev_tgt.size();
    frame_begin(HALF_SLOW);
    send_byte(8'h01, HALF_SLOW, junk);
    for (int i = 0; i < 5; i++) spi_bit(1'b1, HALF_SLOW, s);
    frame_end(HALF_SLOW);
    check("abort ev_count", ev_tgt.size() - base, 0);
    check("abort miso", miso, 1'b0);
    $display("frame abort: ss released mid-byte, %0d strobes", ev_tgt.size() - base);
    tx_arr[0] = 8'h01; tx_arr[1] = 8'h33;
    run_frame("hid", 2, HALF_SLOW, 1'b0);

    // Reset during bit 4 of byte 2
    base = ev_tgt.size();
    frame_begin(HALF_SLOW);
    send_byte(8'h00, HALF_SLOW, junk);
    send_byte(8'h5A, HALF_SLOW, junk);
    for (int i = 0; i < 4; i++) spi_bit(1'b1, HALF_SLOW, s);
    reset = 1'b1;
    @(negedge clk);
    check_idle_outputs("midreset");
    reset = 1'b0;
    for (int i = 0; i < 4; i++) spi_bit(1'b0, HALF_SLOW, s);
    send_byte(8'hE1, HALF_SLOW, junk);
    repeat (HALF_SLOW) @(negedge clk);
    check("midreset ev_count", ev_tgt.size() - base, 1);
    if (ev_tgt.size() > base) check("midreset ev_data", ev_data[base], 8'h5A);
    frame_end(HALF_SLOW);
    $display("frame midreset: %0d strobes before and after reset", ev_tgt.size() - base);
    tx_arr[0] = 8'h00; tx_arr[1] = 8'h00; tx_arr[2] = 8'h77;
    run_frame("postreset", 3, HALF_SLOW, 1'b0);

    // Random 64-byte sys frame at the minimum sclk phase
    tx_arr[0] = 8'h00;
    for (int k = 1; k < 64; k++) tx_arr[k] = 8'($urandom_range(0, 255));
    for (int k = 0; k < 64; k++) reply_tab[k] = 8'($urandom_range(0, 255));
    rand_mode = 1'b1;
    run_frame("rand64", 64, HALF_MIN, 1'b1);
    rand_mode = 1'b0;

    // Short random frames to random valid targets
    for (int f = 0; f < 3; f++) begin
      tx_arr[0] = 8'($urandom_range(1, 3));
      for (int k = 1; k < 6; k++) tx_arr[k] = 8'($urandom_range(0, 255));
      run_frame($sformatf("rnd%0d", f), 6, HALF_MIN, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
